// File: rtl/tri_64x72_ecc_fix_pkg.sv
// Shared SEC-DED definitions for the 64x72 GPR read-side check/correct stage:
// code position table, check-bit generator and syndrome classification.
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 2
`endif

package tri_64x72_ecc_fix_pkg;
  localparam int DATA_W = 64;
  localparam int CHK_W  = 8;
  localparam int ADR_W  = 6;
  localparam int WORD_W = DATA_W + CHK_W;
  localparam int POS_W  = CHK_W - 1;

  typedef struct packed {
    logic ue;
    logic ce;
  } ecc_stat_t;

  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic [WORD_W-1:0] word;
  } scrub_ent_t;

  // Data bit j sits at the j-th code position >= 3 that is not a power of two.
  function automatic logic [DATA_W*POS_W-1:0] build_pos_tab();
    logic [DATA_W*POS_W-1:0] tab;
    int k;
    tab = '0;
    k = 0;
    for (int n = 3; n < WORD_W; n++) begin
      if ((n & (n - 1)) != 0) begin
        tab[k*POS_W +: POS_W] = POS_W'(n);
        k++;
      end
    end
    return tab;
  endfunction

  localparam logic [DATA_W*POS_W-1:0] POS_TAB = build_pos_tab();

  function automatic logic [POS_W-1:0] pos_of(input int j);
    return POS_TAB[j*POS_W +: POS_W];
  endfunction

  function automatic logic [CHK_W-1:0] ecc_gen(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    logic [POS_W-1:0] p;
    c = '0;
    for (int j = 0; j < DATA_W; j++) begin
      p = pos_of(j);
      for (int i = 0; i < POS_W; i++) begin
        if (p[i]) c[i] = c[i] ^ d[j];
      end
    end
    c[CHK_W-1] = ^{d, c[CHK_W-2:0]};
    return c;
  endfunction

  // Odd overall parity with a syndrome that names no bit (>71) is treated as a multi-bit error.
  function automatic ecc_stat_t classify(input logic [POS_W-1:0] s, input logic op);
    ecc_stat_t r;
    r = '0;
    if (!op) r.ue = (s != '0);
    else if (((s & (s - POS_W'(1))) == '0) || (s <= POS_W'(WORD_W - 1))) r.ce = 1'b1;
    else r.ue = 1'b1;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] flip_mask(input logic [POS_W-1:0] s, input logic op);
    logic [DATA_W-1:0] m;
    for (int j = 0; j < DATA_W; j++) m[j] = op && (s == pos_of(j));
    return m;
  endfunction
endpackage

// File: rtl/tri_64x72_ecc_fix_if.sv
// Bus bundle between the array read port, the read consumer and the array write-port arbiter.
interface tri_64x72_ecc_fix_if #(
  parameter int CE_CNT_W = 8
);
  import tri_64x72_ecc_fix_pkg::*;

  logic                rd_val;
  logic [ADR_W-1:0]    rd_adr;
  logic [WORD_W-1:0]   ary_do;
  logic                arch_wr_val;
  logic [ADR_W-1:0]    arch_wr_adr;
  logic                out_val;
  logic [ADR_W-1:0]    out_adr;
  logic [DATA_W-1:0]   out_data;
  logic                out_ce;
  logic                out_ue;
  // wb_req holds the queue head stable on wb_adr/wb_data until a cycle with wb_req & wb_gnt
  // retires it; wb_gnt without wb_req is ignored, and an arch write to the head's address
  // retires it without a write.
  logic                wb_req;
  logic [ADR_W-1:0]    wb_adr;
  logic [WORD_W-1:0]   wb_data;
  logic                wb_gnt;
  logic [CE_CNT_W-1:0] ce_cnt;
  logic                ue_sticky;

  modport slave (
    input  rd_val, rd_adr, ary_do, arch_wr_val, arch_wr_adr, wb_gnt,
    output out_val, out_adr, out_data, out_ce, out_ue, wb_req, wb_adr, wb_data, ce_cnt, ue_sticky
  );

  modport master (
    output rd_val, rd_adr, ary_do, arch_wr_val, arch_wr_adr, wb_gnt,
    input  out_val, out_adr, out_data, out_ce, out_ue, wb_req, wb_adr, wb_data, ce_cnt, ue_sticky
  );
endinterface

// File: rtl/tri_64x72_ecc_fix_gen72.sv
// Combinational check-bit generator for 64 data bits of the 72-bit array word.
module tri_ecc_gen72
  import tri_64x72_ecc_fix_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic [CHK_W-1:0]  o_chk
);
  assign o_chk = ecc_gen(i_data);
endmodule

// File: rtl/tri_64x72_ecc_fix.sv
// SEC-DED check/correct on the GPR array read port with a 2-entry scrub writeback queue,
// a saturating correctable-error counter and a sticky uncorrectable flag.
module tri_64x72_ecc_fix
  import tri_64x72_ecc_fix_pkg::*;
#(
  parameter int NCLK_WIDTH = `NCLK_WIDTH,
  parameter int CE_CNT_W   = 8
) (
  input logic [NCLK_WIDTH-1:0] nclk,
  tri_64x72_ecc_fix_if.slave   bus
);
  logic w_clk;
  logic w_rst;
  logic w_unused;

  logic                r_s1_val;
  logic [ADR_W-1:0]    r_s1_adr;
  logic                r_out_val;
  logic [ADR_W-1:0]    r_out_adr;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_ce;
  logic                r_out_ue;
  logic [CE_CNT_W-1:0] r_ce_cnt;
  logic                r_ue_sticky;
  scrub_ent_t          r_q [2];
  logic [1:0]          r_q_val;

  logic [DATA_W-1:0] w_rd_data;
  logic [CHK_W-1:0]  w_rd_chk;
  logic [CHK_W-1:0]  w_re_chk;
  logic [POS_W-1:0]  w_syn;
  logic              w_op;
  ecc_stat_t         w_stat;
  logic [DATA_W-1:0] w_corr;
  logic [CHK_W-1:0]  w_wb_chk;
  scrub_ent_t        w_enq_ent;
  logic              w_enq;
  logic [1:0]        w_kill;
  logic              w_pop;
  logic              w_keep0;
  logic              w_keep1;
  scrub_ent_t        w_q_nxt [2];
  logic [1:0]        w_q_val_nxt;

  assign w_clk    = nclk[0];
  assign w_rst    = nclk[1];
  assign w_unused = ^{nclk, w_re_chk[CHK_W-1]};

  assign w_rd_data = bus.ary_do[DATA_W-1:0];
  assign w_rd_chk  = bus.ary_do[WORD_W-1:DATA_W];

  tri_ecc_gen72 u_syn_gen (.i_data(w_rd_data), .o_chk(w_re_chk));

  assign w_syn  = w_re_chk[POS_W-1:0] ^ w_rd_chk[POS_W-1:0];
  assign w_op   = ^bus.ary_do;
  assign w_stat = classify(w_syn, w_op);
  // The mask is zero for every UE case, so UE results leave the raw data in place.
  assign w_corr = w_rd_data ^ flip_mask(w_syn, w_op);

  tri_ecc_gen72 u_wb_gen (.i_data(r_out_data), .o_chk(w_wb_chk));

  assign w_enq_ent = '{adr: r_out_adr, word: {w_wb_chk, r_out_data}};
  assign w_enq     = r_out_ce && !(bus.arch_wr_val && (bus.arch_wr_adr == r_out_adr));

  // Slot 0 is always the head; survivors compact toward it before the enqueue is placed.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_kill[i] = r_q_val[i] && bus.arch_wr_val && (r_q[i].adr == bus.arch_wr_adr);
    end
    w_pop       = r_q_val[0] && bus.wb_gnt;
    w_keep0     = r_q_val[0] && !w_kill[0] && !w_pop;
    w_keep1     = r_q_val[1] && !w_kill[1];
    w_q_nxt[0]  = r_q[0];
    w_q_nxt[1]  = r_q[1];
    w_q_val_nxt = '0;
    if (w_keep0) begin
      w_q_val_nxt[0] = 1'b1;
      w_q_val_nxt[1] = w_keep1;
    end else if (w_keep1) begin
      w_q_nxt[0]     = r_q[1];
      w_q_val_nxt[0] = 1'b1;
    end
    if (w_enq) begin
      if (!w_q_val_nxt[0]) begin
        w_q_nxt[0]     = w_enq_ent;
        w_q_val_nxt[0] = 1'b1;
      end else if (!w_q_val_nxt[1]) begin
        w_q_nxt[1]     = w_enq_ent;
        w_q_val_nxt[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_s1_val    <= 1'b0;
      r_s1_adr    <= '0;
      r_out_val   <= 1'b0;
      r_out_adr   <= '0;
      r_out_data  <= '0;
      r_out_ce    <= 1'b0;
      r_out_ue    <= 1'b0;
      r_ce_cnt    <= '0;
      r_ue_sticky <= 1'b0;
      r_q_val     <= '0;
      for (int i = 0; i < 2; i++) r_q[i] <= '0;
    end else begin
      r_s1_val  <= bus.rd_val;
      r_s1_adr  <= bus.rd_adr;
      r_out_val <= r_s1_val;
      r_out_ce  <= r_s1_val && w_stat.ce;
      r_out_ue  <= r_s1_val && w_stat.ue;
      if (r_s1_val) begin
        r_out_adr  <= r_s1_adr;
        r_out_data <= w_corr;
      end
      if (r_s1_val && w_stat.ce && (r_ce_cnt != '1)) r_ce_cnt <= r_ce_cnt + CE_CNT_W'(1);
      if (r_s1_val && w_stat.ue) r_ue_sticky <= 1'b1;
      r_q_val <= w_q_val_nxt;
      for (int i = 0; i < 2; i++) r_q[i] <= w_q_nxt[i];
    end
  end

  assign bus.out_val   = r_out_val;
  assign bus.out_adr   = r_out_adr;
  assign bus.out_data  = r_out_data;
  assign bus.out_ce    = r_out_ce;
  assign bus.out_ue    = r_out_ue;
  assign bus.wb_req    = r_q_val[0];
  assign bus.wb_adr    = r_q[0].adr;
  assign bus.wb_data   = r_q[0].word;
  assign bus.ce_cnt    = r_ce_cnt;
  assign bus.ue_sticky = r_ue_sticky;
endmodule

// File: tb/tb_tri_64x72_ecc_fix.sv
// Directed bench for tri_64x72_ecc_fix: read pipeline, correction cases, scrub queue,
// coherence with architectural writes, counter saturation and mid-flight reset.
module tb_tri_64x72_ecc_fix;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] D3 = 64'h8000_0000_0000_0001;
  localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DB = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] DC = 64'h0000_FFFF_0000_FFFF;

  tri_64x72_ecc_fix_if #(.CE_CNT_W(8)) bus ();

  tri_64x72_ecc_fix #(.NCLK_WIDTH(2), .CE_CNT_W(8)) dut (
    .nclk ({rst, clk}),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Classic positional Hamming layout: code[p] holds the bit at code position p.
  function automatic logic [71:0] enc(input logic [63:0] d);
    logic [71:0] code;
    logic [7:0]  c;
    int k;
    code = '0;
    k = 0;
    for (int p = 3; p < 72; p++) begin
      if (p != 4 && p != 8 && p != 16 && p != 32 && p != 64) begin
        code[p] = d[k];
        k++;
      end
    end
    c = '0;
    for (int i = 0; i < 7; i++) begin
      for (int p = 1; p < 72; p++) begin
        if (p[i]) c[i] = c[i] ^ code[p];
      end
    end
    c[7] = (^d) ^ (^c[6:0]);
    return {c, d};
  endfunction

  function automatic logic [71:0] flip1(input logic [63:0] d, input int b);
    logic [71:0] w;
    w = enc(d);
    w[b] = ~w[b];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    bus.rd_val = 0; bus.arch_wr_val = 0; bus.wb_gnt = 0; bus.ary_do = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic rd(input logic [5:0] adr, input logic [71:0] word);
    bus.rd_val = 1'b1; bus.rd_adr = adr;
    tick();
    bus.rd_val = 1'b0; bus.ary_do = word;
    tick();
    bus.ary_do = '0;
  endtask

  // Back-to-back CE reads to addresses 1,2,3; returns with the third result on the outputs.
  task automatic three_ce();
    bus.rd_val = 1'b1; bus.rd_adr = 6'd1;
    tick();
    bus.rd_adr = 6'd2; bus.ary_do = flip1(DA, 5);
    tick();
    bus.rd_adr = 6'd3; bus.ary_do = flip1(DB, 60);
    tick();
    bus.rd_val = 1'b0; bus.ary_do = flip1(DC, 0);
    tick();
    bus.ary_do = '0;
  endtask

  initial begin
    logic [71:0] w;
    n_pass = 0; n_total = 0;
    bus.rd_adr = '0; bus.arch_wr_adr = '0;
    do_reset();
    rst = 1'b1;
    tick();
    chk("rst_out_val", bus.out_val, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_wb_req", bus.wb_req, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_ce_cnt", bus.ce_cnt, 0);
    chk("rst_ue_sticky", bus.ue_sticky, 0);
    rst = 1'b0;

    // clean word
    rd(6'd5, enc(D0));
    chk("clean_val", bus.out_val, 1);
    chk("clean_adr", bus.out_adr, 5);
    chk("clean_data", bus.out_data, D0);
    chk("clean_ce", bus.out_ce, 0);
    chk("clean_ue", bus.out_ue, 0);
    tick();
    chk("clean_val_drop", bus.out_val, 0);
    chk("clean_no_wb", bus.wb_req, 0);

    // single data flip with scrub and pop
    rd(6'd12, flip1(D1, 17));
    chk("ce_data", bus.out_data, D1);
    chk("ce_flag", bus.out_ce, 1);
    chk("ce_ue", bus.out_ue, 0);
    chk("ce_cnt1", bus.ce_cnt, 1);
    tick();
    chk("ce_wb_req", bus.wb_req, 1);
    chk("ce_wb_adr", bus.wb_adr, 12);
    chk("ce_wb_data", bus.wb_data, enc(D1));
    bus.wb_gnt = 1'b1;
    tick();
    bus.wb_gnt = 1'b0;
    chk("ce_popped", bus.wb_req, 0);

    // double flip
    w = enc(D2); w[3] = ~w[3]; w[40] = ~w[40];
    rd(6'd20, w);
    chk("ue_flag", bus.out_ue, 1);
    chk("ue_ce", bus.out_ce, 0);
    chk("ue_raw_data", bus.out_data, w[63:0]);
    chk("ue_sticky", bus.ue_sticky, 1);
    chk("ue_cnt_hold", bus.ce_cnt, 1);
    tick();
    chk("ue_no_wb", bus.wb_req, 0);

    // check-bit flips and the highest data position
    rd(6'd30, flip1(D0, 66));
    chk("c2_ce", bus.out_ce, 1);
    chk("c2_data", bus.out_data, D0);
    tick();
    chk("c2_wb_adr", bus.wb_adr, 30);
    chk("c2_wb_data", bus.wb_data, enc(D0));
    bus.wb_gnt = 1'b1;
    tick();
    bus.wb_gnt = 1'b0;
    rd(6'd31, flip1(D3, 71));
    chk("c7_ce", bus.out_ce, 1);
    chk("c7_data", bus.out_data, D3);
    rd(6'd32, flip1(D3, 63));
    chk("d63_ce", bus.out_ce, 1);
    chk("d63_data", bus.out_data, D3);
    chk("ce_cnt4", bus.ce_cnt, 4);

    // full queue drops the third entry
    do_reset();
    three_ce();
    chk("q3_cnt", bus.ce_cnt, 3);
    chk("q3_head", bus.wb_adr, 1);
    tick();
    bus.wb_gnt = 1'b1;
    tick();
    chk("q3_second", bus.wb_adr, 2);
    chk("q3_second_data", bus.wb_data, enc(DB));
    tick();
    bus.wb_gnt = 1'b0;
    chk("q3_dropped", bus.wb_req, 0);

    // pop and enqueue on a full queue in the same cycle
    do_reset();
    three_ce();
    bus.wb_gnt = 1'b1;
    tick();
    chk("qpe_head2", bus.wb_adr, 2);
    tick();
    chk("qpe_head3", bus.wb_adr, 3);
    chk("qpe_data3", bus.wb_data, enc(DC));
    tick();
    bus.wb_gnt = 1'b0;
    chk("qpe_empty", bus.wb_req, 0);

    // coherence with architectural writes
    do_reset();
    rd(6'd7, flip1(D0, 9));
    tick();
    chk("coh_req", bus.wb_req, 1);
    chk("coh_adr", bus.wb_adr, 7);
    bus.arch_wr_val = 1'b1; bus.arch_wr_adr = 6'd7; bus.wb_gnt = 1'b1;
    tick();
    bus.arch_wr_val = 1'b0; bus.wb_gnt = 1'b0;
    chk("coh_killed", bus.wb_req, 0);
    rd(6'd9, flip1(D1, 33));
    chk("coh_sup_ce", bus.out_ce, 1);
    bus.arch_wr_val = 1'b1; bus.arch_wr_adr = 6'd9;
    tick();
    bus.arch_wr_val = 1'b0;
    chk("coh_suppressed", bus.wb_req, 0);
    rd(6'd10, flip1(D2, 50));
    tick();
    bus.arch_wr_val = 1'b1; bus.arch_wr_adr = 6'd11;
    tick();
    bus.arch_wr_val = 1'b0;
    chk("coh_other_req", bus.wb_req, 1);
    chk("coh_other_adr", bus.wb_adr, 10);

    // counter saturation
    do_reset();
    for (int i = 0; i < 254; i++) rd(6'(i), flip1(DA ^ 64'(i), i % 72));
    chk("sat_254", bus.ce_cnt, 254);
    rd(6'd1, flip1(DB, 2));
    chk("sat_255", bus.ce_cnt, 255);
    rd(6'd2, flip1(DC, 70));
    chk("sat_hold", bus.ce_cnt, 255);
    chk("sat_q_full", bus.wb_req, 1);

    // reset with two reads in flight and a full queue
    bus.rd_val = 1'b1; bus.rd_adr = 6'd20;
    tick();
    bus.rd_adr = 6'd21; bus.ary_do = flip1(D0, 1);
    rst = 1'b1;
    tick();
    chk("mrst_out_val", bus.out_val, 0);
    chk("mrst_out_ce", bus.out_ce, 0);
    chk("mrst_out_adr", bus.out_adr, 0);
    chk("mrst_out_data", bus.out_data, 0);
    chk("mrst_wb_req", bus.wb_req, 0);
    chk("mrst_wb_adr", bus.wb_adr, 0);
    chk("mrst_wb_data", bus.wb_data, 0);
    chk("mrst_ce_cnt", bus.ce_cnt, 0);
    rst = 1'b0; bus.rd_val = 1'b0;
    tick();
    chk("mrst_no_val1", bus.out_val, 0);
    bus.ary_do = '0;
    tick();
    chk("mrst_no_val2", bus.out_val, 0);
    chk("mrst_no_wb", bus.wb_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
